ser2par_collector: RTL

Serial-to-parallel collector that sits directly downstream of the team's right-shifting load/shift register and consumes its serial bit output. It reassembles LSB-first bit streams into w-bit words and presents them on a valid/ready output port. A two-level buffer (accumulator plus holding register) lets the shifter keep streaming while the consumer drains the previous word. Backpressure is returned to the shifter when both levels are full.

---
 rtl/ser2par_collector.sv | 103 ++++++++++
 1 files changed

// File: rtl/ser2par_collector.sv
// ser2par_collector: rebuilds LSB-first serial bit streams into w-bit words.
// The accumulator and the holding register form a two-level buffer, so the
// shifter can keep streaming while the consumer drains the previous word.
// Once both levels are full, bit_rdy drops until the holding register drains.
module ser2par_collector #(
    parameter int w = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 bit_in,
    input  logic                 bit_vld,
    output logic                 bit_rdy,
    output logic [w-1:0]         data_out,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [$clog2(w)-1:0] bit_cnt
);

    localparam int CW = $clog2(w);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [w-1:0]    acc;
    logic [CW-1:0]   cnt;
    logic            accept;
    logic            complete;
    logic            xfer;
    logic            hold_free;
    logic [w-1:0]    word;

    assign accept    = bit_vld && (state == COLLECT);
    assign complete  = accept && (cnt == CW'(w - 1));
    assign xfer      = out_vld && out_rdy;
    assign hold_free = !out_vld || out_rdy;
    assign word      = {bit_in, acc[w-1:1]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: stall when a word completes with the holding register busy,
    // and leave the stall once that register drains
    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                COLLECT: if (complete && !hold_free) state_nxt = STALL;
                STALL:   if (xfer)                   state_nxt = COLLECT;
                default: state_nxt = COLLECT;
            endcase
        end
    end

    // Outputs decoded from state only, so out_rdy never reaches bit_rdy combinationally
    always_comb begin
        bit_rdy = (state == COLLECT);
        bit_cnt = (state == COLLECT) ? cnt : '0;
    end

    // Accumulator: shift in accepted bits, wrap the count on each completed word
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= word;
            cnt <= complete ? '0 : cnt + CW'(1);
        end else if (state == STALL && xfer) begin
            acc <= '0;
        end
    end

    // Holding register: load a freshly completed word or the stalled word,
    // otherwise drop out_vld after a transfer (data_out keeps its last value)
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            out_vld  <= 1'b0;
        end else if (!clr && complete && hold_free) begin
            data_out <= word;
            out_vld  <= 1'b1;
        end else if (!clr && state == STALL && xfer) begin
            data_out <= acc;
            out_vld  <= 1'b1;
        end else if (xfer) begin
            out_vld  <= 1'b0;
        end
    end

endmodule
